// File: rtl/lightsout_key_scanner_if.sv
// rtl/lightsout_key_scanner_if.sv - key scanner signal bundle between matrix, scanner and game logic
interface lightsout_key_scanner_if;
    logic       scan_en;
    logic [2:0] btn_row;
    logic [2:0] col_sel;
    logic [1:0] col_idx;
    logic       scan_step;
    logic [8:0] key_held;
    logic [8:0] key_press;
    logic [8:0] key_release;

    modport master (
        input  scan_en,
        input  btn_row,
        output col_sel,
        output col_idx,
        output scan_step,
        output key_held,
        output key_press,
        output key_release
    );

    modport slave (
        output scan_en,
        output btn_row,
        input  col_sel,
        input  col_idx,
        input  scan_step,
        input  key_held,
        input  key_press,
        input  key_release
    );
endinterface

// File: rtl/lightsout_key_scanner.sv
// rtl/lightsout_key_scanner.sv - 3x3 button matrix scanner with per-key debounce and press/release strobes
module lightsout_key_scanner #(
    parameter int PRESCALE     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lightsout_key_scanner_if.master    bus
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
    localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_t;

    col_state_t       col_q, col_d;
    logic [2:0]       col_sel;
    logic [15:0]      presc_q, presc_d;
    logic [2:0]       row_meta_q, row_sync_q;
    logic [8:0][3:0]  cnt_q, cnt_d;
    logic [8:0]       held_q, held_d;
    logic [8:0]       press_q, press_d;
    logic [8:0]       release_q, release_d;
    logic             step;
    logic [3:0]       key;
    logic             sample;

    // Two-flop synchroniser on the asynchronous row returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
        end else begin
            row_meta_q <= bus.btn_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Last dwell cycle of the current column; nothing advances while scanning is paused
    assign step = bus.scan_en && (presc_q == PS_LAST);

    // Dwell prescaler next value: hold when paused, wrap on the step cycle
    always_comb begin
        presc_d = presc_q;
        if (bus.scan_en) begin
            presc_d = step ? 16'd0 : presc_q + 16'd1;
        end
    end

    // Column FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= COL0;
        end else begin
            col_q <= col_d;
        end
    end

    // Column FSM next state and one-hot column drive
    always_comb begin
        col_d   = col_q;
        col_sel = 3'b001;
        case (col_q)
            COL0: begin
                col_sel = 3'b001;
                if (step) col_d = COL1;
            end
            COL1: begin
                col_sel = 3'b010;
                if (step) col_d = COL2;
            end
            COL2: begin
                col_sel = 3'b100;
                if (step) col_d = COL0;
            end
            default: begin
                col_sel = 3'b001;
                col_d   = COL0;
            end
        endcase
    end

    // Debounce the three keys of the active column on its step; strobes default to zero
    always_comb begin
        held_d    = held_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        key       = '0;
        sample    = 1'b0;
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                key    = 4'(r * 3) + {2'b00, col_q};
                sample = row_sync_q[r];
                if (sample == held_q[key]) begin
                    cnt_d[key] = '0;
                end else if (cnt_q[key] == DB_LAST) begin
                    held_d[key]    = sample;
                    cnt_d[key]     = '0;
                    press_d[key]   = sample;
                    release_d[key] = ~sample;
                end else begin
                    cnt_d[key] = cnt_q[key] + 4'd1;
                end
            end
        end
    end

    // Prescaler, debounce counters, key levels and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.col_sel     = col_sel;
    assign bus.col_idx     = col_q;
    assign bus.scan_step   = step;
    assign bus.key_held    = held_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;

endmodule

// File: tb/tb_lightsout_key_scanner.sv
// tb/tb_lightsout_key_scanner.sv - scoreboard bench for lightsout_key_scanner
module tb_lightsout_key_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] pressed = '0;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [8:0] press;
        logic [8:0] rel;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    lightsout_key_scanner_if bus ();

    lightsout_key_scanner #(
        .PRESCALE     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Physical matrix: a pressed key connects its column drive to its row return
    assign bus.btn_row = {|(pressed[8:6] & bus.col_sel),
                          |(pressed[5:3] & bus.col_sel),
                          |(pressed[2:0] & bus.col_sel)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_ev(input logic [8:0] p, input logic [8:0] r);
        ev_t e;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    // Monitor: every nonzero strobe cycle must match the next expected event
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && ((bus.key_press | bus.key_release) != 9'd0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: actual press=%0h release=%0h required none at %0t",
                         bus.key_press, bus.key_release, $time);
            end else begin
                e = exp_q.pop_front();
                check("strobe_press", 32'(bus.key_press), 32'(e.press));
                check("strobe_release", 32'(bus.key_release), 32'(e.rel));
            end
        end
    end

    // Advance to the negedge just after the step edge of column c
    task automatic wait_step_of(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.scan_step && (int'(bus.col_idx) == c)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("step_timeout", 32'(n), 32'd0);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic wait_col_start(input int c);
        wait_step_of((c + 2) % 3);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] sel_hold;
        logic [1:0] idx_hold;

        bus.scan_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_col_sel", 32'(bus.col_sel), 32'h1);
        check("rst_col_idx", 32'(bus.col_idx), 32'h0);
        check("rst_scan_step", 32'(bus.scan_step), 32'h0);
        check("rst_key_held", 32'(bus.key_held), 32'h0);
        check("rst_key_press", 32'(bus.key_press), 32'h0);
        check("rst_key_release", 32'(bus.key_release), 32'h0);

        // Test 1: column rotation, 4 clk per column, step on the 4th
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            check("t1_col_sel", 32'(bus.col_sel), 32'(3'b001 << ((k / 4) % 3)));
            check("t1_scan_step", 32'(bus.scan_step), 32'((k % 4) == 3));
            check("t1_key_held", 32'(bus.key_held), 32'h0);
            @(negedge clk);
        end

        // Test 2: key 4 press then release
        wait_col_start(1);
        pressed = 9'h010;
        push_ev(9'h010, 9'h000);
        repeat (3) wait_step_of(1);
        check("t2_held_set", 32'(bus.key_held), 32'h010);
        @(negedge clk);
        check("t2_press_one_clk", 32'(bus.key_press), 32'h0);
        pressed = 9'h000;
        push_ev(9'h000, 9'h010);
        repeat (3) wait_step_of(1);
        check("t2_held_clr", 32'(bus.key_held), 32'h0);
        drain("t2");

        // Test 3: bounce on key 0, then a clean press and release
        wait_col_start(0);
        pressed = 9'h001;
        repeat (2) wait_step_of(0);
        pressed = 9'h000;
        repeat (2) wait_step_of(0);
        check("t3_bounce_held", 32'(bus.key_held), 32'h0);
        pressed = 9'h001;
        push_ev(9'h001, 9'h000);
        repeat (3) wait_step_of(0);
        check("t3_held_set", 32'(bus.key_held), 32'h001);
        pressed = 9'h000;
        push_ev(9'h000, 9'h001);
        repeat (3) wait_step_of(0);
        check("t3_held_clr", 32'(bus.key_held), 32'h0);
        drain("t3");

        // Test 4: all rows held across all columns
        wait_col_start(0);
        pressed = 9'h1FF;
        push_ev(9'h049, 9'h000);
        push_ev(9'h092, 9'h000);
        push_ev(9'h124, 9'h000);
        repeat (3) wait_step_of(2);
        check("t4_held_all", 32'(bus.key_held), 32'h1FF);
        pressed = 9'h000;
        push_ev(9'h000, 9'h049);
        push_ev(9'h000, 9'h092);
        push_ev(9'h000, 9'h124);
        repeat (3) wait_step_of(2);
        check("t4_held_none", 32'(bus.key_held), 32'h0);
        drain("t4");

        // Test 5: pause mid-debounce of key 8
        wait_col_start(2);
        pressed = 9'h100;
        push_ev(9'h100, 9'h000);
        wait_step_of(2);
        repeat (2) @(negedge clk);
        sel_hold = bus.col_sel;
        idx_hold = bus.col_idx;
        bus.scan_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t5_col_sel_frozen", 32'(bus.col_sel), 32'(sel_hold));
            check("t5_col_idx_frozen", 32'(bus.col_idx), 32'(idx_hold));
            check("t5_no_step", 32'(bus.scan_step), 32'h0);
        end
        check("t5_held_frozen", 32'(bus.key_held), 32'h0);
        bus.scan_en = 1'b1;
        wait_step_of(2);
        check("t5_held_after_2nd", 32'(bus.key_held), 32'h0);
        wait_step_of(2);
        check("t5_held_after_3rd", 32'(bus.key_held), 32'h100);
        drain("t5");

        // Test 6: asynchronous reset with a key held
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        pressed = 9'h000;
        #1;
        check("t6_async_held", 32'(bus.key_held), 32'h0);
        check("t6_async_col_sel", 32'(bus.col_sel), 32'h1);
        check("t6_async_col_idx", 32'(bus.col_idx), 32'h0);
        check("t6_async_step", 32'(bus.scan_step), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_release_col_sel", 32'(bus.col_sel), 32'h1);
        repeat (40) @(negedge clk);
        check("t6_held_after", 32'(bus.key_held), 32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
